ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
AHB-lite slave that converts single AHB transfers into APB3 transfers for the peripheral subsystem. It drives the HREADYAHBAPB, HRESPAHBAPB and HRDATAAHBAPB inputs of the central slave-to-master multiplexor, and is selected by HSELAHBAPB from the system decoder. The bridge decodes the address into one-hot APB peripheral selects. Unmapped peripheral slots return an AHB ERROR.

Parameters:
ADDR_WIDTH, 16, width of PADDR. PADDR = HADDR[ADDR_WIDTH-1:0] with bits [1:0] forced to 0.
NUM_SLV, 4, number of APB peripheral selects (1..16).
SLV_SHIFT, 12, peripheral index = HADDR[SLV_SHIFT+3:SLV_SHIFT]. Index >= NUM_SLV is unmapped.

Ports:
HCLK  input  1  system bus clock
HRESETn  input  1  reset, asynchronous, active-low
HSEL  input  1  bridge select from decoder
HADDR  input  32  AHB address
HTRANS  input  2  AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HWRITE  input  1  AHB write flag
HWDATA  input  32  AHB write data (data phase)
HREADYIn  input  1  system HREADY (address-phase sample enable)
HREADYOut  output  1  bridge ready to S2M mux
HRESP  output  2  bridge response (OKAY=00, ERROR=01)
HRDATA  output  32  bridge read data
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  NUM_SLV  one-hot APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data (externally muxed)
PREADY  input  1  APB ready (externally muxed)
PSLVERR  input  1  APB slave error (externally muxed)

Behaviour:
- Reset values:
  - HREADYOut=1, HRESP=00, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - State IDLE.
- Reset assertion mid-transfer:
  - Forces IDLE immediately and drops PSEL/PENABLE asynchronously.
  - No completion is signalled.
- Valid transfer: HSEL=1, HTRANS[1]=1 and HREADYIn=1 at a rising edge. HADDR and HWRITE are registered on that edge. BUSY and IDLE transfers are ignored.
- State machine: IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
  - IDLE: HREADYOut=1, HRESP=00.
    - Valid mapped transfer -> LATCH.
    - Valid unmapped transfer -> ERR1.
  - LATCH: HREADYOut=0. Captures HWDATA into PWDATA on writes; PWDATA is unchanged on reads. -> SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0, PADDR and PWRITE valid, HREADYOut=0. -> ACCESS.
  - ACCESS: PSEL held, PENABLE=1, HREADYOut=0.
    - PREADY=0: stay; unbounded wait.
    - PREADY=1, PSLVERR=0: capture PRDATA into HRDATA on reads only -> DONE.
    - PREADY=1, PSLVERR=1: HRDATA unchanged -> ERR1.
    - PSEL and PENABLE drop on leaving ACCESS.
  - DONE: HREADYOut=1, HRESP=00.
    - Valid mapped transfer sampled this cycle -> LATCH.
    - Valid unmapped transfer -> ERR1.
    - Otherwise -> IDLE.
  - ERR1: HREADYOut=0, HRESP=01. -> ERR2.
  - ERR2: HREADYOut=1, HRESP=01. Samples the next transfer exactly as DONE does. A master cancellation (HTRANS=IDLE) -> IDLE.
- Latency:
  - Mapped transfer with zero APB wait: HREADYOut is low for 3 data-phase cycles (LATCH, SETUP, ACCESS) and high in the 4th.
  - Each PREADY=0 cycle adds 1.
  - Unmapped transfer: 2 data-phase cycles (ERR1, ERR2).
- Outputs are registered: HREADYOut, HRESP, HRDATA, PSEL, PENABLE, PADDR, PWRITE and PWDATA are all flop outputs.
- HRDATA holds the last successful read value between transfers. Writes and errors do not modify it.
- PADDR, PWRITE and PWDATA hold their values after a transfer until the next SETUP.
- Back-to-back: a transfer sampled in DONE or ERR2 starts LATCH on the next cycle with no IDLE gap.
- HSEL=0 while in IDLE: zero-wait OKAY (HREADYOut=1).

Test Plan:
- Reset: assert HRESETn=0 mid-ACCESS -> PSEL=0, PENABLE=0, HREADYOut=1, HRESP=00 immediately; after release the bridge is IDLE and ignores HTRANS=IDLE.
- Write, zero wait: NONSEQ write HADDR=0x0000_1004, HWDATA=0xA5A5_5A5A, PREADY=1 -> SETUP with PSEL=4'b0010, PADDR=0x1004, PWRITE=1, PWDATA=0xA5A5_5A5A; HREADYOut low 3 cycles, high in the 4th with HRESP=00.
- Read with 2 APB waits: HADDR=0x0000_0008, PREADY low 2 ACCESS cycles then high with PRDATA=0xDEAD_BEEF -> HREADYOut low 5 cycles; HRDATA=0xDEAD_BEEF when HREADYOut=1.
- PSLVERR: read at 0x3000 with PREADY=1, PSLVERR=1 -> HRESP=01 with HREADYOut=0, then HRESP=01 with HREADYOut=1; HRDATA retains its prior value.
- Unmapped: NUM_SLV=4, HADDR=0x0000_5000 -> no PSEL activity; ERR1 then ERR2 two-cycle ERROR response.
- Back-to-back/cancel: SEQ write sampled in DONE -> LATCH the next cycle with no IDLE gap; HTRANS=IDLE driven during ERR1 -> bridge returns to IDLE after ERR2 with no APB access.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-lite to APB3 bridge.
// Each AHB transfer becomes one APB access. The address is decoded into
// one-hot peripheral selects, and an unmapped slot gets a two-cycle AHB
// ERROR response. Every bus-facing output comes straight from a flop.

module ahb_apb_bridge_chk #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SLV    = 4
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  input logic [NUM_SLV-1:0]    PSEL,
  input logic                  PENABLE,
  input logic                  PREADY,
  input logic [ADDR_WIDTH-1:0] PADDR,
  input logic                  PWRITE,
  input logic                  HREADYOut,
  input logic [1:0]            HRESP
);

  // at most one peripheral is ever selected
  a_psel_onehot : assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot0(PSEL))
    else $error("bridge selects more than one peripheral");

  // the enable phase only exists with a peripheral selected
  a_penable_sel : assert property (@(posedge HCLK) disable iff (!HRESETn)
    PENABLE |-> (PSEL != '0))
    else $error("PENABLE without PSEL");

  // a wait-stated access keeps select, address and direction steady
  a_access_hold : assert property (@(posedge HCLK) disable iff (!HRESETn)
    (PENABLE && !PREADY) |=> (PENABLE && $stable(PSEL) && $stable(PADDR) && $stable(PWRITE)))
    else $error("APB access changed while waiting");

  // the bridge never answers with a reserved response code
  a_hresp_legal : assert property (@(posedge HCLK) disable iff (!HRESETn)
    !HRESP[1])
    else $error("illegal HRESP");

  // no APB activity while the AHB side sees a ready data phase
  a_ready_idle_apb : assert property (@(posedge HCLK) disable iff (!HRESETn)
    HREADYOut |-> (PSEL == '0))
    else $error("PSEL active while HREADYOut high");

endmodule

module ahb_apb_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SLV    = 4,
  parameter int SLV_SHIFT  = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIn,
  output logic                  HREADYOut,
  output logic [1:0]            HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_hready;
  logic                  w_hready_nxt;
  logic [1:0]            r_hresp;
  logic [1:0]            w_hresp_nxt;
  logic [NUM_SLV-1:0]    r_psel;
  logic [NUM_SLV-1:0]    w_psel_nxt;
  logic                  r_penable;
  logic                  w_penable_nxt;
  logic [31:0]           r_hrdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_idx;
  logic                  r_hwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [31:0]           r_pwdata;

  logic                  w_valid;
  logic                  w_sample;
  logic                  w_hit;
  logic [3:0]            w_idx;
  logic                  w_unused;

  // one-hot select for a peripheral index
  function automatic logic [NUM_SLV-1:0] f_decode(input logic [3:0] idx);
    logic [NUM_SLV-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      v[i] = (idx == 4'(i));
    end
    return v;
  endfunction

  // index lands on an implemented peripheral slot
  function automatic logic f_mapped(input logic [3:0] idx);
    return ({28'd0, idx} < 32'(NUM_SLV));
  endfunction

  assign w_idx    = HADDR[SLV_SHIFT+3:SLV_SHIFT];
  assign w_valid  = HSEL & HTRANS[1] & HREADYIn;
  assign w_hit    = f_mapped(w_idx);
  // a new address phase is only accepted while the bridge drives HREADY high
  assign w_sample = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  // address bits outside PADDR/index and the BUSY/SEQ distinction are don't-cares
  assign w_unused = ^{HADDR, HTRANS[0]};

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_valid) begin
          if (w_hit) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_state_nxt = S_ERR1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LATCH:  w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            w_state_nxt = S_ERR1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ERR1:   w_state_nxt = S_ERR2;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // bus outputs decoded from the state being entered, so they can be registered
  always_comb begin
    w_hready_nxt  = 1'b0;
    w_hresp_nxt   = RESP_OKAY;
    w_psel_nxt    = '0;
    w_penable_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE, S_DONE: w_hready_nxt = 1'b1;
      S_LATCH:        w_hready_nxt = 1'b0;
      S_SETUP:        w_psel_nxt   = f_decode(r_idx);
      S_ACCESS: begin
        w_psel_nxt    = f_decode(r_idx);
        w_penable_nxt = 1'b1;
      end
      S_ERR1:         w_hresp_nxt  = RESP_ERROR;
      S_ERR2: begin
        w_hready_nxt = 1'b1;
        w_hresp_nxt  = RESP_ERROR;
      end
      default:        w_hready_nxt = 1'b1;
    endcase
  end

  // state and handshake flops; reset drops the APB select at once
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_hready  <= 1'b1;
      r_hresp   <= RESP_OKAY;
      r_psel    <= '0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hready  <= w_hready_nxt;
      r_hresp   <= w_hresp_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
    end
  end

  // capture the AHB address phase of an accepted transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr   <= '0;
      r_idx    <= 4'd0;
      r_hwrite <= 1'b0;
    end else if (w_sample && w_valid) begin
      r_addr   <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
      r_idx    <= w_idx;
      r_hwrite <= HWRITE;
    end
  end

  // APB address, direction and write data become valid for SETUP and then hold
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= 32'd0;
    end else if (r_state == S_LATCH) begin
      r_paddr  <= r_addr;
      r_pwrite <= r_hwrite;
      if (r_hwrite) begin
        r_pwdata <= HWDATA;
      end
    end
  end

  // read data only changes on a successful read completion
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= 32'd0;
    end else if ((r_state == S_ACCESS) && PREADY && !PSLVERR && !r_hwrite) begin
      r_hrdata <= PRDATA;
    end
  end

  assign HREADYOut = r_hready;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;

  ahb_apb_bridge_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLV    (NUM_SLV)
  ) u_chk (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PSEL      (r_psel),
    .PENABLE   (r_penable),
    .PREADY    (PREADY),
    .PADDR     (r_paddr),
    .PWRITE    (r_pwrite),
    .HREADYOut (r_hready),
    .HRESP     (r_hresp)
  );

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed scenarios plus a
// randomized transfer stream against a transaction-level model.

module tb_ahb_apb_bridge;

  localparam int AW = 16;
  localparam int NS = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADYIn;
  logic          HREADYOut;
  logic [1:0]    HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] PADDR;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int            n_cmp = 0;
  int            n_err = 0;

  // APB slave behaviour for the current transfer
  int            cfg_waits = 0;
  logic          cfg_err   = 1'b0;
  logic [31:0]   cfg_rdata = 32'd0;

  // model state: last successful read data and last APB write data
  logic [31:0]   m_hrdata = 32'd0;
  logic [31:0]   m_pwdata = 32'd0;

  typedef struct {
    int            low;
    logic [1:0]    resp_last_low;
    logic [1:0]    resp_end;
    logic [31:0]   rdata_end;
    int            psel_cyc;
    logic [NS-1:0] psel;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
  } obs_t;

  ahb_apb_bridge #(
    .ADDR_WIDTH (AW),
    .NUM_SLV    (NS),
    .SLV_SHIFT  (12)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADYIn  (HREADYIn),
    .HREADYOut (HREADYOut),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // APB slave: inserts cfg_waits wait states per access, random noise outside ACCESS
  initial begin : apb_slave
    int acc;
    acc     = 0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'd0;
    forever begin
      @(negedge HCLK);
      if ((PSEL != '0) && PENABLE) begin
        if (acc < cfg_waits) begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom);
          PRDATA  = $urandom;
          acc++;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = cfg_err;
          PRDATA  = cfg_rdata;
        end
      end else begin
        acc     = 0;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
    end
  end

  // drive one address phase; returns one cycle into the data phase with HWDATA set
  task automatic start_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [1:0] trans);
    HSEL     = 1'b1;
    HADDR    = addr;
    HTRANS   = trans;
    HWRITE   = wr;
    HREADYIn = 1'b1;
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = $urandom;
    HWRITE = 1'($urandom);
    HWDATA = wdata;
  endtask

  // observe the data phase until HREADYOut is high (returns at that negedge)
  task automatic wait_done(output obs_t o);
    o.low = 0; o.resp_last_low = 2'b11; o.resp_end = 2'b11; o.rdata_end = 32'd0;
    o.psel_cyc = 0; o.psel = '0; o.paddr = '0; o.pwrite = 1'b0; o.pwdata = 32'd0;
    for (int c = 0; c < 64; c++) begin
      @(negedge HCLK);
      if (PSEL != '0) o.psel_cyc++;
      if ((PSEL != '0) && !PENABLE) begin
        o.psel   = PSEL;
        o.paddr  = PADDR;
        o.pwrite = PWRITE;
        o.pwdata = PWDATA;
      end
      if (HREADYOut) begin
        o.resp_end  = HRESP;
        o.rdata_end = HRDATA;
        return;
      end
      o.low++;
      o.resp_last_low = HRESP;
    end
    o.low = -1;
  endtask

  task automatic test_reset();
    logic [88:0] got;
    logic [88:0] exp;
    bit          seen;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    got = {HREADYOut, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA};
    exp = {1'b1, 2'b00, 32'd0, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", got, exp);
    end
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    cfg_waits = 6;
    cfg_err   = 1'b0;
    start_xfer(32'h0000_2010, 1'b1, 32'h1234_5678, 2'b10);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge HCLK);
      if (PENABLE) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_reach_access: got no ACCESS expected ACCESS within 10 cycles");
    end
    #2 HRESETn = 1'b0;
    #1;
    got = {HREADYOut, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA};
    exp = {1'b1, 2'b00, 32'd0, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_mid_access: got %h expected %h", got, exp);
    end
    #3 HRESETn = 1'b1;
    m_hrdata = 32'd0;
    m_pwdata = 32'd0;
    HSEL     = 1'b1;
    HTRANS   = 2'b00;
    HREADYIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      n_cmp++;
      if ({HREADYOut, HRESP, PSEL, PENABLE} !== {1'b1, 2'b00, 4'd0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle_ignore: got rdy=%b resp=%b psel=%b pen=%b expected rdy=1 resp=00 psel=0000 pen=0",
                 HREADYOut, HRESP, PSEL, PENABLE);
      end
    end
    HSEL = 1'b0;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_write_zero_wait();
    obs_t o;
    cfg_waits = 0;
    cfg_err   = 1'b0;
    start_xfer(32'h0000_1004, 1'b1, 32'hA5A5_5A5A, 2'b10);
    wait_done(o);
    m_pwdata = 32'hA5A5_5A5A;
    n_cmp++;
    if ((o.low !== 3) || (o.resp_end !== 2'b00)) begin
      n_err++;
      $display("FAIL write_latency: got low=%0d resp=%b expected low=3 resp=00", o.low, o.resp_end);
    end
    n_cmp++;
    if ({o.psel, o.paddr, o.pwrite, o.pwdata} !== {4'b0010, 16'h1004, 1'b1, 32'hA5A5_5A5A}) begin
      n_err++;
      $display("FAIL write_setup: got psel=%b paddr=%h pwrite=%b pwdata=%h expected psel=0010 paddr=1004 pwrite=1 pwdata=a5a55a5a",
               o.psel, o.paddr, o.pwrite, o.pwdata);
    end
    @(negedge HCLK);
    n_cmp++;
    if ({PSEL, PADDR, PWRITE, PWDATA} !== {4'd0, 16'h1004, 1'b1, 32'hA5A5_5A5A}) begin
      n_err++;
      $display("FAIL write_hold: got psel=%b paddr=%h pwrite=%b pwdata=%h expected psel=0000 paddr=1004 pwrite=1 pwdata=a5a55a5a",
               PSEL, PADDR, PWRITE, PWDATA);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_read_wait();
    obs_t o;
    cfg_waits = 2;
    cfg_err   = 1'b0;
    cfg_rdata = 32'hDEAD_BEEF;
    start_xfer(32'h0000_0008, 1'b0, 32'h5555_AAAA, 2'b10);
    wait_done(o);
    n_cmp++;
    if ((o.low !== 5) || (o.resp_end !== 2'b00) || (o.rdata_end !== 32'hDEAD_BEEF)) begin
      n_err++;
      $display("FAIL read_wait: got low=%0d resp=%b hrdata=%h expected low=5 resp=00 hrdata=deadbeef",
               o.low, o.resp_end, o.rdata_end);
    end
    n_cmp++;
    if ({o.psel, o.paddr, o.pwrite, o.pwdata} !== {4'b0001, 16'h0008, 1'b0, m_pwdata}) begin
      n_err++;
      $display("FAIL read_setup: got psel=%b paddr=%h pwrite=%b pwdata=%h expected psel=0001 paddr=0008 pwrite=0 pwdata=%h",
               o.psel, o.paddr, o.pwrite, o.pwdata, m_pwdata);
    end
    m_hrdata = 32'hDEAD_BEEF;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_slverr();
    obs_t o;
    cfg_waits = 0;
    cfg_err   = 1'b1;
    cfg_rdata = 32'h0BAD_F00D;
    start_xfer(32'h0000_3000, 1'b0, 32'd0, 2'b10);
    wait_done(o);
    n_cmp++;
    if ((o.low !== 4) || (o.resp_last_low !== 2'b01) || (o.resp_end !== 2'b01)) begin
      n_err++;
      $display("FAIL slverr_resp: got low=%0d resp_low=%b resp_end=%b expected low=4 resp_low=01 resp_end=01",
               o.low, o.resp_last_low, o.resp_end);
    end
    n_cmp++;
    if ((o.rdata_end !== m_hrdata) || (o.psel !== 4'b1000)) begin
      n_err++;
      $display("FAIL slverr_data: got hrdata=%h psel=%b expected hrdata=%h psel=1000",
               o.rdata_end, o.psel, m_hrdata);
    end
    cfg_err = 1'b0;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_unmapped();
    obs_t o;
    start_xfer(32'h0000_5000, 1'b1, 32'hFFFF_0000, 2'b10);
    wait_done(o);
    n_cmp++;
    if ((o.low !== 1) || (o.resp_last_low !== 2'b01) || (o.resp_end !== 2'b01) || (o.psel_cyc !== 0)) begin
      n_err++;
      $display("FAIL unmapped: got low=%0d resp_low=%b resp_end=%b psel_cycles=%0d expected 1/01/01/0",
               o.low, o.resp_last_low, o.resp_end, o.psel_cyc);
    end
    @(negedge HCLK);
    n_cmp++;
    if ({HREADYOut, HRESP, PWDATA, HRDATA} !== {1'b1, 2'b00, m_pwdata, m_hrdata}) begin
      n_err++;
      $display("FAIL unmapped_after: got rdy=%b resp=%b pwdata=%h hrdata=%h expected 1 00 %h %h",
               HREADYOut, HRESP, PWDATA, HRDATA, m_pwdata, m_hrdata);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    logic [31:0] rd;
    bit          bad;
    cfg_waits = 0;
    cfg_err   = 1'b0;
    start_xfer(32'h0000_2000, 1'b1, 32'h1111_2222, 2'b10);
    wait_done(o);
    n_cmp++;
    if (o.low !== 3) begin
      n_err++;
      $display("FAIL b2b_first: got low=%0d expected low=3", o.low);
    end
    // SEQ write presented during DONE
    start_xfer(32'h0000_2004, 1'b1, 32'h3333_4444, 2'b11);
    wait_done(o);
    m_pwdata = 32'h3333_4444;
    n_cmp++;
    if ((o.low !== 3) || ({o.psel, o.paddr, o.pwdata} !== {4'b0100, 16'h2004, 32'h3333_4444})) begin
      n_err++;
      $display("FAIL b2b_from_done: got low=%0d psel=%b paddr=%h pwdata=%h expected low=3 psel=0100 paddr=2004 pwdata=33334444",
               o.low, o.psel, o.paddr, o.pwdata);
    end
    @(posedge HCLK);
    #1;
    // read presented during ERR2 of an unmapped transfer
    start_xfer(32'h0000_4000, 1'b0, 32'd0, 2'b10);
    wait_done(o);
    rd        = $urandom;
    cfg_rdata = rd;
    start_xfer(32'h0000_0ABC, 1'b0, 32'd0, 2'b10);
    wait_done(o);
    m_hrdata = rd;
    n_cmp++;
    if ((o.low !== 3) || (o.rdata_end !== rd) || (o.paddr !== 16'h0ABC) || (o.resp_end !== 2'b00)) begin
      n_err++;
      $display("FAIL b2b_from_err2: got low=%0d hrdata=%h paddr=%h resp=%b expected low=3 hrdata=%h paddr=0abc resp=00",
               o.low, o.rdata_end, o.paddr, o.resp_end, rd);
    end
    @(posedge HCLK);
    #1;
    // master cancels with IDLE during ERR1
    start_xfer(32'h0000_7000, 1'b1, 32'd0, 2'b10);
    wait_done(o);
    n_cmp++;
    if ((o.low !== 1) || (o.resp_end !== 2'b01)) begin
      n_err++;
      $display("FAIL cancel_err: got low=%0d resp=%b expected low=1 resp=01", o.low, o.resp_end);
    end
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      if ({HREADYOut, HRESP, PSEL, PENABLE} !== {1'b1, 2'b00, 4'd0, 1'b0}) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL cancel_idle: got rdy=%b resp=%b psel=%b expected idle OKAY with no PSEL",
               HREADYOut, HRESP, PSEL);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_ignored();
    logic [3:0] pat [5];
    bit         bad;
    // {HSEL, HTRANS, HREADYIn}
    pat[0] = 4'b1_01_1;
    pat[1] = 4'b1_00_1;
    pat[2] = 4'b1_10_0;
    pat[3] = 4'b0_10_1;
    pat[4] = 4'b0_11_1;
    for (int p = 0; p < 5; p++) begin
      HSEL     = pat[p][3];
      HTRANS   = pat[p][2:1];
      HREADYIn = pat[p][0];
      HADDR    = 32'h0000_1000;
      HWRITE   = 1'b1;
      @(posedge HCLK);
      #1;
      HSEL     = 1'b0;
      HTRANS   = 2'b00;
      HREADYIn = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge HCLK);
        if ({HREADYOut, HRESP, PSEL} !== {1'b1, 2'b00, 4'd0}) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL ignored_%0d: got rdy=%b resp=%b psel=%b expected no transfer started",
                 p, HREADYOut, HRESP, PSEL);
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_random();
    obs_t          o;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rd;
    logic          wr;
    logic          err;
    int            waits;
    bit            mapped;
    bit            chained;
    int            exp_low;
    logic [1:0]    exp_resp;
    logic [NS-1:0] exp_psel;
    logic [AW-1:0] exp_paddr;
    chained = 1'b0;
    for (int k = 0; k < 60; k++) begin
      addr        = $urandom;
      addr[15:12] = 4'($urandom_range(5, 0));
      wr          = 1'($urandom);
      wdata       = $urandom;
      waits       = $urandom_range(3, 0);
      err         = ($urandom_range(4, 0) == 0);
      rd          = $urandom;
      cfg_waits   = waits;
      cfg_err     = err;
      cfg_rdata   = rd;
      mapped      = (int'(addr[15:12]) < NS);
      start_xfer(addr, wr, wdata, chained ? {1'b1, 1'($urandom)} : 2'b10);
      wait_done(o);
      exp_low   = !mapped ? 1 : (err ? 4 + waits : 3 + waits);
      exp_resp  = (!mapped || err) ? 2'b01 : 2'b00;
      exp_psel  = '0;
      if (mapped) exp_psel[addr[13:12]] = 1'b1;
      exp_paddr = {addr[15:2], 2'b00};
      if (mapped && wr) m_pwdata = wdata;
      if (mapped && !err && !wr) m_hrdata = rd;
      n_cmp++;
      if ((o.low !== exp_low) || (o.resp_end !== exp_resp) || (o.rdata_end !== m_hrdata)) begin
        n_err++;
        $display("FAIL rand_%0d_resp: got low=%0d resp=%b hrdata=%h expected low=%0d resp=%b hrdata=%h",
                 k, o.low, o.resp_end, o.rdata_end, exp_low, exp_resp, m_hrdata);
      end
      n_cmp++;
      if (o.psel_cyc !== (mapped ? 2 + waits : 0)) begin
        n_err++;
        $display("FAIL rand_%0d_psel_cycles: got %0d expected %0d",
                 k, o.psel_cyc, mapped ? 2 + waits : 0);
      end
      if (mapped) begin
        n_cmp++;
        if ({o.psel, o.paddr, o.pwrite, o.pwdata} !== {exp_psel, exp_paddr, wr, m_pwdata}) begin
          n_err++;
          $display("FAIL rand_%0d_setup: got psel=%b paddr=%h pwrite=%b pwdata=%h expected psel=%b paddr=%h pwrite=%b pwdata=%h",
                   k, o.psel, o.paddr, o.pwrite, o.pwdata, exp_psel, exp_paddr, wr, m_pwdata);
        end
      end
      chained = 1'($urandom);
      if (!chained) begin
        @(posedge HCLK);
        #1;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  // global time bound
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    HRESETn  = 1'b0;
    HSEL     = 1'b0;
    HADDR    = 32'd0;
    HTRANS   = 2'b00;
    HWRITE   = 1'b0;
    HWDATA   = 32'd0;
    HREADYIn = 1'b1;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_unmapped();
    test_back_to_back();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
